frame_min_max: RTL and testbench

Streaming reduction stage that sits directly downstream of the `lt` comparator datapath. It accepts a stream of WIDTH-bit samples with a valid/ready handshake and reports the minimum and maximum of each frame, with their sample indices. It performs its ordering decisions with the same strict less-than semantics as `lt`. Frames close after FRAME_LEN samples or on `in_last`, whichever comes first.

---
 rtl/frame_min_max.sv | 91 +++++++++
 tb/tb_frame_min_max.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_min_max.sv
// Per-frame minimum/maximum reduction over a valid/ready sample stream.
// Ordering uses strict less-than, so ties keep the first occurrence index.
module frame_min_max #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAME_LEN = 16,
  parameter bit          SIGNED    = 1'b1,
  localparam int unsigned CW       = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
  output logic [CW-1:0]    out_min_idx,
  output logic [CW-1:0]    out_max_idx,
  output logic [CW-1:0]    out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {StEmpty, StAccum, StHold} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_min;
  logic [WIDTH-1:0] r_max;
  logic [CW-1:0]    r_min_idx;
  logic [CW-1:0]    r_max_idx;
  logic [CW-1:0]    r_count;

  logic          w_accept;
  logic          w_lt_min;
  logic          w_lt_max;
  logic          w_close;
  logic [CW-1:0] w_count_inc;

  function automatic logic lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED) return $signed(a) < $signed(b);
    else        return a < b;
  endfunction

  // in_ready depends only on state, out_ready and reset, never on in_valid/in_data.
  assign in_ready    = rst_n & ((r_state != StHold) | out_ready);
  assign w_accept    = in_valid & in_ready;
  assign w_lt_min    = lt(in_data, r_min);
  assign w_lt_max    = lt(r_max, in_data);
  assign w_count_inc = r_count + CW'(1);
  assign w_close     = in_last | (w_count_inc == CW'(FRAME_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StEmpty;
      r_min     <= '0;
      r_max     <= '0;
      r_min_idx <= '0;
      r_max_idx <= '0;
      r_count   <= '0;
    end else if (w_accept && r_state != StAccum) begin
      // Seeding a new frame; from HOLD this also completes the output handshake.
      r_min     <= in_data;
      r_max     <= in_data;
      r_min_idx <= '0;
      r_max_idx <= '0;
      r_count   <= CW'(1);
      r_state   <= in_last ? StHold : StAccum;
    end else if (w_accept) begin
      if (w_lt_min) begin
        r_min     <= in_data;
        r_min_idx <= r_count;
      end
      if (w_lt_max) begin
        r_max     <= in_data;
        r_max_idx <= r_count;
      end
      r_count <= w_count_inc;
      if (w_close) r_state <= StHold;
    end else if (r_state == StHold && out_ready) begin
      r_state <= StEmpty;
    end
  end

  assign out_min     = r_min;
  assign out_max     = r_max;
  assign out_min_idx = r_min_idx;
  assign out_max_idx = r_max_idx;
  assign out_count   = r_count;
  assign out_valid   = (r_state == StHold);

endmodule

// File: tb/tb_frame_min_max.sv
// Bench for frame_min_max: signed and unsigned instances share one stimulus stream,
// a frame model feeds per-instance scoreboards, and scenario tasks add direct checks.
module tb_frame_min_max;
  localparam int W  = 32;
  localparam int FL = 4;
  localparam int CW = $clog2(FL + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b1;

  logic          s_in_ready, u_in_ready;
  logic [W-1:0]  s_min, s_max, u_min, u_max;
  logic [CW-1:0] s_min_idx, s_max_idx, s_count, u_min_idx, u_max_idx, u_count;
  logic          s_out_valid, u_out_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_res = 0;
  int res_cyc[$];

  typedef struct packed {
    logic [W-1:0]  mn;
    logic [W-1:0]  mx;
    logic [CW-1:0] mni;
    logic [CW-1:0] mxi;
    logic [CW-1:0] cnt;
  } res_t;

  res_t         exp_s[$];
  res_t         exp_u[$];
  logic [W-1:0] frame[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frame_min_max #(.WIDTH(W), .FRAME_LEN(FL), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(s_in_ready), .out_min(s_min), .out_max(s_max), .out_min_idx(s_min_idx),
    .out_max_idx(s_max_idx), .out_count(s_count), .out_valid(s_out_valid),
    .out_ready(out_ready)
  );

  frame_min_max #(.WIDTH(W), .FRAME_LEN(FL), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(u_in_ready), .out_min(u_min), .out_max(u_max), .out_min_idx(u_min_idx),
    .out_max_idx(u_max_idx), .out_count(u_count), .out_valid(u_out_valid),
    .out_ready(out_ready)
  );

  function automatic bit lt_m(logic [W-1:0] a, logic [W-1:0] b, bit sgn);
    if (sgn) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  function automatic res_t reduce(bit sgn);
    res_t r;
    r.mn  = frame[0];
    r.mx  = frame[0];
    r.mni = '0;
    r.mxi = '0;
    r.cnt = CW'(frame.size());
    for (int k = 1; k < frame.size(); k++) begin
      if (lt_m(frame[k], r.mn, sgn)) begin r.mn = frame[k]; r.mni = CW'(k); end
      if (lt_m(r.mx, frame[k], sgn)) begin r.mx = frame[k]; r.mxi = CW'(k); end
    end
    return r;
  endfunction

  // Inputs change #1 after posedge, so the negedge sees what the next posedge will act on.
  always @(negedge clk) begin
    res_t r;
    if (!rst_n) begin
      frame.delete();
    end else begin
      if (s_out_valid && out_ready) begin
        n_res++;
        res_cyc.push_back(cyc);
        checks++;
        if (exp_s.size() == 0) begin
          errors++;
          $display("FAIL sb_signed_unexpected: got result min=%h max=%h, required none",
                   s_min, s_max);
        end else begin
          r = exp_s.pop_front();
          if ({s_min, s_max, s_min_idx, s_max_idx, s_count} !== r) begin
            errors++;
            $display("FAIL sb_signed: got min=%h/%0d max=%h/%0d cnt=%0d, required min=%h/%0d max=%h/%0d cnt=%0d",
                     s_min, s_min_idx, s_max, s_max_idx, s_count,
                     r.mn, r.mni, r.mx, r.mxi, r.cnt);
          end
        end
      end
      if (u_out_valid && out_ready) begin
        checks++;
        if (exp_u.size() == 0) begin
          errors++;
          $display("FAIL sb_unsigned_unexpected: got result min=%h max=%h, required none",
                   u_min, u_max);
        end else begin
          r = exp_u.pop_front();
          if ({u_min, u_max, u_min_idx, u_max_idx, u_count} !== r) begin
            errors++;
            $display("FAIL sb_unsigned: got min=%h/%0d max=%h/%0d cnt=%0d, required min=%h/%0d max=%h/%0d cnt=%0d",
                     u_min, u_min_idx, u_max, u_max_idx, u_count,
                     r.mn, r.mni, r.mx, r.mxi, r.cnt);
          end
        end
      end
      if (in_valid && s_in_ready) begin
        n_acc++;
        frame.push_back(in_data);
        if (in_last || frame.size() == FL) begin
          exp_s.push_back(reduce(1'b1));
          exp_u.push_back(reduce(1'b0));
          frame.delete();
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input bit last);
    bit ok = 1'b0;
    int guard = 0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    while (!ok && guard < 50) begin
      @(negedge clk);
      ok = s_in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 50 cycles");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (s_out_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_out_valid, s_in_ready, u_in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: out_valid/in_ready_s/in_ready_u=%b, required 000",
               {s_out_valid, s_in_ready, u_in_ready});
    end
    checks++;
    if ({s_min, s_max, s_min_idx, s_max_idx, s_count} !== '0) begin
      errors++;
      $display("FAIL reset_data: min=%h max=%h idx=%0d/%0d cnt=%0d, required all 0",
               s_min, s_max, s_min_idx, s_max_idx, s_count);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", s_in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int nv = 0;
    out_ready = 1'b1;
    send(32'd5, 1'b0);
    send(-32'sd3, 1'b0);
    send(32'd7, 1'b0);
    send(-32'sd3, 1'b0);
    idle();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (s_out_valid) begin
        if (nv == 0) begin
          checks++;
          if ({s_min, s_min_idx, s_max, s_max_idx, s_count} !==
              {32'hFFFF_FFFD, 3'd1, 32'd7, 3'd2, 3'd4}) begin
            errors++;
            $display("FAIL basic_result: min=%h/%0d max=%h/%0d cnt=%0d, required fffffffd/1 7/2 cnt=4",
                     s_min, s_min_idx, s_max, s_max_idx, s_count);
          end
        end
        nv++;
      end
    end
    checks++;
    if (nv != 1) begin
      errors++;
      $display("FAIL basic_valid_cycles: out_valid high %0d cycles, required 1", nv);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_early();
    bit ok;
    send(32'd10, 1'b0);
    send(32'd2, 1'b1);
    idle();
    wait_valid(ok);
    checks++;
    if (!ok || {s_min, s_min_idx, s_max, s_max_idx, s_count} !==
               {32'd2, 3'd1, 32'd10, 3'd0, 3'd2}) begin
      errors++;
      $display("FAIL early_result: valid=%b min=%h/%0d max=%h/%0d cnt=%0d, required 2/1 a/0 cnt=2",
               ok, s_min, s_min_idx, s_max, s_max_idx, s_count);
    end
    @(posedge clk);
    #1;
    send(32'd3, 1'b0);
    send(32'd9, 1'b1);
    idle();
    wait_valid(ok);
    checks++;
    if (!ok || {s_min, s_min_idx, s_max, s_max_idx, s_count} !==
               {32'd3, 3'd0, 32'd9, 3'd1, 3'd2}) begin
      errors++;
      $display("FAIL early_next_index: valid=%b min=%h/%0d max=%h/%0d cnt=%0d, required 3/0 9/1 cnt=2",
               ok, s_min, s_min_idx, s_max, s_max_idx, s_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_unsigned();
    bit ok;
    send(32'hFFFF_FFFF, 1'b0);
    send(32'd1, 1'b0);
    send(32'h8000_0000, 1'b0);
    send(32'd0, 1'b0);
    idle();
    wait_valid(ok);
    checks++;
    if (!ok || {u_min, u_min_idx, u_max, u_max_idx} !==
               {32'd0, 3'd3, 32'hFFFF_FFFF, 3'd0}) begin
      errors++;
      $display("FAIL unsigned_result: valid=%b min=%h/%0d max=%h/%0d, required 0/3 ffffffff/0",
               ok, u_min, u_min_idx, u_max, u_max_idx);
    end
    checks++;
    if ({s_min, s_min_idx, s_max, s_max_idx} !== {32'h8000_0000, 3'd2, 32'd1, 3'd1}) begin
      errors++;
      $display("FAIL signed_same_data: min=%h/%0d max=%h/%0d, required 80000000/2 1/1",
               s_min, s_min_idx, s_max, s_max_idx);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int a0;
    out_ready = 1'b0;
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b0);
    send(32'd4, 1'b0);
    in_data  = 32'd100;
    in_last  = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({s_in_ready, s_out_valid} !== 2'b01 ||
          {s_min, s_min_idx, s_max, s_max_idx, s_count} !== {32'd1, 3'd0, 32'd4, 3'd3, 3'd4}) begin
        errors++;
        $display("FAIL bp_hold: in_ready=%b valid=%b min=%h/%0d max=%h/%0d cnt=%0d, required 0 1 1/0 4/3 cnt=4",
                 s_in_ready, s_out_valid, s_min, s_min_idx, s_max, s_max_idx, s_count);
      end
      @(posedge clk);
      #1;
    end
    a0 = n_acc;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_in_ready, s_out_valid} !== 2'b11) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b valid=%b, required 1 1", s_in_ready, s_out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (n_acc != a0 + 1 || s_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_same_cycle: accepts=%0d valid=%b, required %0d 0",
               n_acc - a0, s_out_valid, 1);
    end
    send(32'd50, 1'b0);
    send(32'd300, 1'b1);
    idle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int c0, r0, n;
    out_ready = 1'b1;
    c0 = cyc;
    r0 = n_res;
    for (int k = 0; k < 12; k++) send($urandom, 1'b0);
    checks++;
    if (cyc - c0 != 12) begin
      errors++;
      $display("FAIL b2b_throughput: 12 accepts took %0d cycles, required 12", cyc - c0);
    end
    idle();
    repeat (4) @(posedge clk);
    #1;
    n = res_cyc.size();
    checks++;
    if (n_res - r0 != 3) begin
      errors++;
      $display("FAIL b2b_results: got %0d results, required 3", n_res - r0);
    end else if (res_cyc[n-1] - res_cyc[n-2] != 4 || res_cyc[n-2] - res_cyc[n-3] != 4) begin
      errors++;
      $display("FAIL b2b_spacing: gaps %0d,%0d cycles, required 4,4",
               res_cyc[n-2] - res_cyc[n-3], res_cyc[n-1] - res_cyc[n-2]);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    send(32'd6, 1'b0);
    send(-32'sd5, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_out_valid, u_out_valid, s_in_ready, s_count} !== {3'b000, 3'd0}) begin
      errors++;
      $display("FAIL areset_now: valid_s/valid_u/in_ready=%b cnt=%0d, required 000 0",
               {s_out_valid, u_out_valid, s_in_ready}, s_count);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) send(32'd1, 1'b0);
    idle();
    wait_valid(ok);
    checks++;
    if (!ok || {s_min, s_min_idx, s_max, s_max_idx, s_count} !==
               {32'd1, 3'd0, 32'd1, 3'd0, 3'd4}) begin
      errors++;
      $display("FAIL areset_fresh: valid=%b min=%h/%0d max=%h/%0d cnt=%0d, required 1/0 1/0 cnt=4",
               ok, s_min, s_min_idx, s_max, s_max_idx, s_count);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_early();
    test_unsigned();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_s.size() != 0 || exp_u.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: pending signed=%0d unsigned=%0d, required 0 0",
               exp_s.size(), exp_u.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
